// File: rtl/delay_timer_arb.sv
// Round-robin arbiter in front of one shared tick-based delay timer.
// Optional owner-abort support is enabled by defining DTA_ABORT_EN.
module delay_timer_arb #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned DW         = 8,
  parameter int unsigned TICK_VALUE = 20000000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] delay,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   aborted,
  output logic              busy
);

  localparam int unsigned PW = (TICK_VALUE > 1) ? $clog2(TICK_VALUE) : 1;
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] owner_oh;

  logic            found;
  logic [IW-1:0]   win;
  logic [IW-1:0]   idx;
  logic [DW-1:0]   win_delay;

  // Search starts one past the last winner so the last winner ranks last.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IW'((32'(ptr_q) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign win_delay = delay[win*DW +: DW];
  assign owner_oh  = NREQ'(1) << owner_q;

`ifdef DTA_ABORT_EN
  logic [NREQ-1:0] aborted_q, aborted_d;
  assign aborted = aborted_q;
`else
  assign aborted = '0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
`ifdef DTA_ABORT_EN
    aborted_d = '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (found) begin
          owner_d = win;
          ptr_d   = win;
          cnt_d   = win_delay;
          presc_d = '0;
          state_d = (win_delay == '0) ? StDone : StRun;
        end
      end
      StRun: begin
`ifdef DTA_ABORT_EN
        if (!req[owner_q]) begin
          state_d   = StIdle;
          aborted_d = owner_oh;
        end else
`endif
        if (presc_q == PW'(TICK_VALUE - 1)) begin
          presc_d = '0;
          if (cnt_q <= DW'(1)) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q - DW'(1);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= IW'(NREQ - 1);
      presc_q <= '0;
      cnt_q   <= '0;
`ifdef DTA_ABORT_EN
      aborted_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
`ifdef DTA_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign busy  = (state_q != StIdle);
  assign grant = busy ? owner_oh : '0;
  assign done  = (state_q == StDone) ? owner_oh : '0;

endmodule

// File: tb/tb_delay_timer_arb.sv
// Bench for delay_timer_arb: event-time reference model checked every cycle plus
// directed scenarios with literal expectations (NREQ=4, DW=8, TICK_VALUE=4).
module tb_delay_timer_arb;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TV   = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] delay;
  logic [NREQ-1:0]   grant, done, aborted;
  logic              busy;

  int vectors = 0;
  int fails   = 0;
  bit chk_en  = 1'b0;
  int now     = 0;

  delay_timer_arb #(
    .NREQ       (NREQ),
    .DW         (DW),
    .TICK_VALUE (TV)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req),
    .delay   (delay),
    .grant   (grant),
    .done    (done),
    .aborted (aborted),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Reference model: owner plus the absolute cycle number of its done pulse.
  int cyc     = 0;
  int m_owner = -1;
  int m_last  = NREQ - 1;
  int m_done  = 0;
  logic [NREQ-1:0] m_ab = '0;

  always @(posedge clk) begin
    logic [NREQ-1:0] ab_n;
    ab_n = '0;
    if (!rstn) begin
      m_owner = -1;
      m_last  = NREQ - 1;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int w;
        w = (m_last + k) % NREQ;
        if (m_owner < 0 && req[w]) begin
          m_owner = w;
          m_last  = w;
          m_done  = cyc + 1 + int'(delay[w*DW +: DW]) * TV;
        end
      end
    end else if (cyc == m_done) begin
      m_owner = -1;
    end
`ifdef DTA_ABORT_EN
    else if (!req[m_owner]) begin
      ab_n    = NREQ'(1) << m_owner;
      m_owner = -1;
    end
`endif
    m_ab = ab_n;
    cyc  = cyc + 1;
  end

  always @(negedge clk) begin
    logic [NREQ-1:0] eg, ed;
    logic            eb;
    if (chk_en) begin
      eb = (m_owner >= 0);
      eg = eb ? (NREQ'(1) << m_owner) : '0;
      ed = (eb && cyc == m_done) ? eg : '0;
      vectors++;
      if (grant !== eg || done !== ed || aborted !== m_ab || busy !== eb) begin
        fails++;
        $display("FAIL model cyc=%0d: grant/done/aborted/busy got %b/%b/%b/%b want %b/%b/%b/%b",
                 cyc, grant, done, aborted, busy, eg, ed, m_ab, eb);
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", nm, now, act, exp);
    end
  endtask

  task automatic at(input int k);
    while (now < k) begin
      @(negedge clk);
      now++;
    end
  endtask

  // Leaves the bench at a negedge with rstn just released; that is cycle 0.
  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    req  = '0;
    @(negedge clk);
    @(negedge clk);
    rstn   = 1'b1;
    chk_en = 1'b1;
    now    = 0;
  endtask

  function automatic logic [NREQ*DW-1:0] dl(input int d3, input int d2, input int d1,
                                            input int d0);
    return {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
  endfunction

  initial begin
    rstn  = 1'b0;
    req   = '0;
    delay = '0;

    // Single request, delay 3.
    do_reset();
    lit("reset_grant", grant, 0);
    lit("reset_busy", busy, 0);
    req = 4'b0001; delay = dl(0, 0, 0, 3);
    at(1);  lit("s1_grant_c1", grant, 4'b0001);
    at(12); lit("s1_done_c12", done, 0);
    at(13); lit("s1_done_c13", done, 4'b0001); req = '0;
    at(14); lit("s1_busy_c14", busy, 0);
    at(16);

    // Two requesters held; owner delay changed after acceptance.
    do_reset();
    req = 4'b0101; delay = dl(0, 1, 0, 2);
    at(1);  lit("s2_grant_c1", grant, 4'b0001);
    at(3);  delay = dl(0, 1, 0, 7);
    at(9);  lit("s2_done_c9", done, 4'b0001);
    at(10); lit("s2_idle_c10", grant, 0);
    at(11); lit("s2_grant_c11", grant, 4'b0100);
    at(15); lit("s2_done_c15", done, 4'b0100);
    at(17); lit("s2_grant_c17", grant, 4'b0001);
    at(20);

    // All four, delay 1: full rotation and wrap back to 0.
    do_reset();
    req = 4'b1111; delay = dl(1, 1, 1, 1);
    at(5);  lit("s3_done0", done, 4'b0001);
    at(11); lit("s3_done1", done, 4'b0010);
    at(17); lit("s3_done2", done, 4'b0100);
    at(19); lit("s3_grant3", grant, 4'b1000);
    at(23); lit("s3_done3", done, 4'b1000);
    at(25); lit("s3_grant0_again", grant, 4'b0001);
    at(27);

    // Zero delay skips RUN.
    do_reset();
    req = 4'b0100; delay = dl(0, 0, 0, 0);
    at(1);  lit("s4_grant", grant, 4'b0100); lit("s4_done", done, 4'b0100); req = '0;
    at(2);  lit("s4_busy", busy, 0);
    at(4);

    // Reset in the middle of RUN.
    do_reset();
    req = 4'b0001; delay = dl(0, 0, 0, 5);
    at(8);  lit("s5_busy_run", busy, 1); rstn = 1'b0;
    at(9);  lit("s5_rst_grant", grant, 0); lit("s5_rst_done", done, 0);
            lit("s5_rst_busy", busy, 0); rstn = 1'b1;
    at(10); lit("s5_regrant", grant, 4'b0001);
    at(14);

    // Owner drops req in its 6th RUN cycle.
    do_reset();
    req = 4'b0010; delay = dl(0, 0, 10, 0);
    at(6);  req = '0;
`ifdef DTA_ABORT_EN
    at(7);  lit("s6_aborted", aborted, 4'b0010); lit("s6_ab_grant", grant, 0);
    at(8);  lit("s6_ab_clear", aborted, 0);
`else
    at(40); lit("s6_done_c40", done, 0);
    at(41); lit("s6_done_c41", done, 4'b0010); lit("s6_aborted", aborted, 0);
`endif
    at(44);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
